alu_issue_stage: RTL and testbench

- ID/EX pipeline boundary directly upstream of the ALU.
- Captures a decoded instruction from the decode stage, detects load-use hazards and inserts bubbles, and supports flush on branch redirect.
- Resolves operand forwarding from the MEM and WB stages, then presents a, b and ctrl to the ALU.
- Keeps a wrapping count of inserted bubbles for performance monitoring.

---
 rtl/alu_issue_stage_if.sv | 74 +++++++
 rtl/alu_issue_stage.sv | 131 +++++++++++++
 tb/tb_alu_issue_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// ALU operation encoding shared by the issue stage and its neighbours, plus the
// bundle of decode, forwarding and ALU-facing signals around the ID/EX boundary.
package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ops_t;
endpackage

interface alu_issue_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    // Decode-side handshake and decoded instruction fields
    logic                        in_valid;
    logic                        in_ready;
    logic [REG_AW-1:0]           in_rs1;
    logic [REG_AW-1:0]           in_rs2;
    logic [XLEN-1:0]             in_rs1_data;
    logic [XLEN-1:0]             in_rs2_data;
    logic [XLEN-1:0]             in_imm;
    logic                        in_use_imm;
    logic [REG_AW-1:0]           in_rd;
    logic                        in_reg_write;
    logic                        in_mem_read;
    alu_issue_pkg::alu_ops_t     in_alu_op;
    // Pipeline control
    logic                        flush;
    logic                        ex_ready;
    // Forwarding sources
    logic [REG_AW-1:0]           mem_rd;
    logic                        mem_reg_write;
    logic [XLEN-1:0]             mem_result;
    logic [REG_AW-1:0]           wb_rd;
    logic                        wb_reg_write;
    logic [XLEN-1:0]             wb_result;
    // Towards the ALU / EX stage
    logic                        ex_valid;
    logic [XLEN-1:0]             alu_a;
    logic [XLEN-1:0]             alu_b;
    alu_issue_pkg::alu_ops_t     alu_ctrl;
    logic [REG_AW-1:0]           ex_rd;
    logic                        ex_reg_write;
    logic                        ex_mem_read;
    logic [31:0]                 bubble_count;

    // Environment side: drives the decoded instruction and pipeline context
    modport master (
        output in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
               in_use_imm, in_rd, in_reg_write, in_mem_read, in_alu_op,
               flush, ex_ready, mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_result,
        input  in_ready, ex_valid, alu_a, alu_b, alu_ctrl, ex_rd,
               ex_reg_write, ex_mem_read, bubble_count
    );

    // Issue stage side
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
               in_use_imm, in_rd, in_reg_write, in_mem_read, in_alu_op,
               flush, ex_ready, mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_result,
        output in_ready, ex_valid, alu_a, alu_b, alu_ctrl, ex_rd,
               ex_reg_write, ex_mem_read, bubble_count
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX boundary in front of the ALU: captures decoded instructions, inserts a
// one-cycle bubble on load-use hazards, honours flush, and forwards MEM/WB
// results onto the ALU operands combinationally from the held register values.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_stage_if.slave    bus
);
    import alu_issue_pkg::*;

    // Held instruction (ID/EX register)
    logic                r_vld_p1;
    logic [REG_AW-1:0]   r_rs1_p1;
    logic [REG_AW-1:0]   r_rs2_p1;
    logic [XLEN-1:0]     r_rs1_data_p1;
    logic [XLEN-1:0]     r_rs2_data_p1;
    logic [XLEN-1:0]     r_imm_p1;
    logic                r_use_imm_p1;
    logic [REG_AW-1:0]   r_rd_p1;
    logic                r_reg_write_p1;
    logic                r_mem_read_p1;
    alu_ops_t            r_alu_op_p1;
    logic [31:0]         r_bubble_cnt;

    logic                w_hold;
    logic                w_load_use;
    logic                w_rs1_hit;
    logic                w_rs2_hit;

    // Pick the youngest in-flight value for a source register; x0 always reads
    // the captured value so a stray write to x0 downstream is never observed.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   reg_data,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_we,
        input logic [XLEN-1:0]   mem_res,
        input logic [REG_AW-1:0] wb_rd,
        input logic              wb_we,
        input logic [XLEN-1:0]   wb_res
    );
        logic [XLEN-1:0] sel;
        sel = reg_data;
        if (rs != '0) begin
            if (mem_we && (mem_rd == rs)) begin
                sel = mem_res;
            end else if (wb_we && (wb_rd == rs)) begin
                sel = wb_res;
            end
        end
        return sel;
    endfunction

    // Hazard detection: a held load whose rd feeds the incoming instruction.
    // rs2 only counts when the instruction actually reads it.
    always_comb begin
        w_hold     = r_vld_p1 & ~bus.ex_ready;
        w_rs1_hit  = (r_rd_p1 == bus.in_rs1);
        w_rs2_hit  = (r_rd_p1 == bus.in_rs2) & ~bus.in_use_imm;
        w_load_use = r_vld_p1 & r_mem_read_p1 & (r_rd_p1 != '0) & bus.in_valid
                   & (w_rs1_hit | w_rs2_hit);
    end

    assign bus.in_ready = ~w_hold & ~w_load_use & ~bus.flush;

    // ---- stage boundary: decode -> ID/EX register ----
    // Pipeline register update; flush outranks hold, hold outranks bubbling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1       <= 1'b0;
            r_rs1_p1       <= '0;
            r_rs2_p1       <= '0;
            r_rs1_data_p1  <= '0;
            r_rs2_data_p1  <= '0;
            r_imm_p1       <= '0;
            r_use_imm_p1   <= 1'b0;
            r_rd_p1        <= '0;
            r_reg_write_p1 <= 1'b0;
            r_mem_read_p1  <= 1'b0;
            r_alu_op_p1    <= ALU_ADD;
            r_bubble_cnt   <= '0;
        end else if (bus.flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_hold) begin
            r_vld_p1 <= r_vld_p1;
        end else if (w_load_use) begin
            r_vld_p1     <= 1'b0;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else if (bus.in_valid) begin
            r_vld_p1       <= 1'b1;
            r_rs1_p1       <= bus.in_rs1;
            r_rs2_p1       <= bus.in_rs2;
            r_rs1_data_p1  <= bus.in_rs1_data;
            r_rs2_data_p1  <= bus.in_rs2_data;
            r_imm_p1       <= bus.in_imm;
            r_use_imm_p1   <= bus.in_use_imm;
            r_rd_p1        <= bus.in_rd;
            r_reg_write_p1 <= bus.in_reg_write;
            r_mem_read_p1  <= bus.in_mem_read;
            r_alu_op_p1    <= bus.in_alu_op;
        end else begin
            r_vld_p1 <= 1'b0;
        end
    end

    // ---- stage boundary: ID/EX register -> ALU (combinational forwarding) ----
    always_comb begin
        bus.alu_a = fwd_sel(r_rs1_p1, r_rs1_data_p1,
                            bus.mem_rd, bus.mem_reg_write, bus.mem_result,
                            bus.wb_rd, bus.wb_reg_write, bus.wb_result);
        if (r_use_imm_p1) begin
            bus.alu_b = r_imm_p1;
        end else begin
            bus.alu_b = fwd_sel(r_rs2_p1, r_rs2_data_p1,
                                bus.mem_rd, bus.mem_reg_write, bus.mem_result,
                                bus.wb_rd, bus.wb_reg_write, bus.wb_result);
        end
    end

    // Side effects of an empty slot must never leak downstream.
    assign bus.ex_valid     = r_vld_p1;
    assign bus.alu_ctrl     = r_alu_op_p1;
    assign bus.ex_rd        = r_rd_p1;
    assign bus.ex_reg_write = r_vld_p1 & r_reg_write_p1;
    assign bus.ex_mem_read  = r_vld_p1 & r_mem_read_p1;
    assign bus.bubble_count = r_bubble_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, a mid-stall
// asynchronous reset sequence, then randomized traffic against a reference model.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic clk;
    logic rst;

    alu_issue_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [31:0] d1;
        logic [4:0]  rs2;
        logic [31:0] d2;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        alu_ops_t    op;
    } ins_t;

    typedef struct {
        ins_t        ins;
        logic        flush;
        logic        exr;
        logic [4:0]  mem_rd;
        logic        mem_we;
        logic [31:0] mem_res;
        logic [4:0]  wb_rd;
        logic        wb_we;
        logic [31:0] wb_res;
        logic        e_ready;
        logic        e_valid;
        logic        e_rw;
        logic        e_mr;
        logic [31:0] e_bub;
        logic        chk_ab;
        logic [31:0] e_a;
        logic [31:0] e_b;
        alu_ops_t    e_ctrl;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk_ins(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                                    input logic [4:0] rs2, input logic [31:0] d2,
                                    input logic use_imm, input logic [31:0] imm,
                                    input logic [4:0] rd, input logic rw, input logic mr,
                                    input alu_ops_t op);
        ins_t r;
        r.v = v; r.rs1 = rs1; r.d1 = d1; r.rs2 = rs2; r.d2 = d2;
        r.use_imm = use_imm; r.imm = imm; r.rd = rd; r.rw = rw; r.mr = mr; r.op = op;
        return r;
    endfunction

    function automatic vec_t mk_vec(input ins_t ins, input logic flush, input logic exr,
                                    input logic [4:0] mem_rd, input logic mem_we, input logic [31:0] mem_res,
                                    input logic [4:0] wb_rd, input logic wb_we, input logic [31:0] wb_res,
                                    input logic e_ready, input logic e_valid, input logic e_rw,
                                    input logic e_mr, input logic [31:0] e_bub, input logic chk_ab,
                                    input logic [31:0] e_a, input logic [31:0] e_b, input alu_ops_t e_ctrl);
        vec_t r;
        r.ins = ins; r.flush = flush; r.exr = exr;
        r.mem_rd = mem_rd; r.mem_we = mem_we; r.mem_res = mem_res;
        r.wb_rd = wb_rd; r.wb_we = wb_we; r.wb_res = wb_res;
        r.e_ready = e_ready; r.e_valid = e_valid; r.e_rw = e_rw; r.e_mr = e_mr;
        r.e_bub = e_bub; r.chk_ab = chk_ab; r.e_a = e_a; r.e_b = e_b; r.e_ctrl = e_ctrl;
        return r;
    endfunction

    task automatic drive(input ins_t i, input logic flush, input logic exr,
                         input logic [4:0] mem_rd, input logic mem_we, input logic [31:0] mem_res,
                         input logic [4:0] wb_rd, input logic wb_we, input logic [31:0] wb_res);
        bus.in_valid      = i.v;
        bus.in_rs1        = i.rs1;
        bus.in_rs1_data   = i.d1;
        bus.in_rs2        = i.rs2;
        bus.in_rs2_data   = i.d2;
        bus.in_use_imm    = i.use_imm;
        bus.in_imm        = i.imm;
        bus.in_rd         = i.rd;
        bus.in_reg_write  = i.rw;
        bus.in_mem_read   = i.mr;
        bus.in_alu_op     = i.op;
        bus.flush         = flush;
        bus.ex_ready      = exr;
        bus.mem_rd        = mem_rd;
        bus.mem_reg_write = mem_we;
        bus.mem_result    = mem_res;
        bus.wb_rd         = wb_rd;
        bus.wb_reg_write  = wb_we;
        bus.wb_result     = wb_res;
    endtask

    // Reference model: the held instruction as a slot plus a bubble tally.
    logic        m_v;
    ins_t        m_h;
    int unsigned m_bub;

    function automatic logic [31:0] m_src(input logic [4:0] rs, input logic [31:0] d,
                                          input logic [4:0] mem_rd, input logic mem_we, input logic [31:0] mem_res,
                                          input logic [4:0] wb_rd, input logic wb_we, input logic [31:0] wb_res);
        if (rs == 5'd0) return d;
        if (mem_we && mem_rd == rs) return mem_res;
        if (wb_we && wb_rd == rs) return wb_res;
        return d;
    endfunction

    vec_t tab[$];
    ins_t nop, add12, i2, i3, ld, subx, ld2, immop, i5, cur;

    initial begin
        nop   = mk_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD);
        add12 = mk_ins(1, 1, 32'd10, 2, 32'd20, 0, 0, 4, 1, 0, ALU_ADD);
        i2    = mk_ins(1, 5, 32'h55, 6, 32'h66, 0, 0, 7, 1, 0, ALU_SUB);
        i3    = mk_ins(1, 0, 32'h33, 6, 32'h44, 0, 0, 8, 1, 0, ALU_OR);
        ld    = mk_ins(1, 1, 32'h100, 0, 0, 1, 32'd4, 3, 1, 1, ALU_ADD);
        subx  = mk_ins(1, 9, 32'h90, 3, 32'h30, 0, 0, 10, 1, 0, ALU_SUB);
        ld2   = mk_ins(1, 2, 32'h200, 0, 0, 1, 32'd8, 3, 1, 1, ALU_ADD);
        immop = mk_ins(1, 4, 32'h40, 3, 32'h30, 1, 32'hFFFF_FFF0, 11, 1, 0, ALU_AND);
        i5    = mk_ins(1, 1, 32'd1, 2, 32'd2, 0, 0, 12, 1, 0, ALU_XOR);

        //                 ins    fl exr mrd mwe mres    wrd wwe wres    rdy vld rw mr bub ab  a            b             ctrl
        tab.push_back(mk_vec(add12, 0, 1, 0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 0, 1, 32'h0,       32'h0,        ALU_ADD));
        tab.push_back(mk_vec(i2,    0, 1, 0, 0, 0,      0, 0, 0,      1, 1, 1, 0, 0, 1, 32'd10,      32'd20,       ALU_ADD));
        tab.push_back(mk_vec(i3,    0, 1, 5, 1, 32'h11, 5, 1, 32'h22, 1, 1, 1, 0, 0, 1, 32'h11,      32'h66,       ALU_SUB));
        tab.push_back(mk_vec(ld,    0, 1, 0, 1, 32'h11, 0, 1, 32'h22, 1, 1, 1, 0, 0, 1, 32'h33,      32'h44,       ALU_OR));
        tab.push_back(mk_vec(subx,  0, 1, 0, 0, 0,      6, 1, 32'h77, 0, 1, 1, 1, 0, 1, 32'h100,     32'd4,        ALU_ADD));
        tab.push_back(mk_vec(subx,  0, 1, 0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 1, 0, 32'h0,       32'h0,        ALU_ADD));
        tab.push_back(mk_vec(ld2,   0, 1, 3, 1, 32'hABC, 0, 0, 0,     1, 1, 1, 0, 1, 1, 32'h90,      32'hABC,      ALU_SUB));
        tab.push_back(mk_vec(immop, 0, 1, 0, 0, 0,      0, 0, 0,      1, 1, 1, 1, 1, 1, 32'h200,     32'd8,        ALU_ADD));
        tab.push_back(mk_vec(i5,    0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 1, 1, 32'h40,      32'hFFFF_FFF0, ALU_AND));
        tab.push_back(mk_vec(i5,    0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 1, 1, 32'h40,      32'hFFFF_FFF0, ALU_AND));
        tab.push_back(mk_vec(i5,    0, 0, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 1, 1, 32'h40,      32'hFFFF_FFF0, ALU_AND));
        tab.push_back(mk_vec(i5,    1, 1, 0, 0, 0,      0, 0, 0,      0, 1, 1, 0, 1, 1, 32'h40,      32'hFFFF_FFF0, ALU_AND));
        tab.push_back(mk_vec(nop,   0, 1, 0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 1, 0, 32'h0,       32'h0,        ALU_ADD));
        tab.push_back(mk_vec(nop,   0, 1, 0, 0, 0,      0, 0, 0,      1, 0, 0, 0, 1, 0, 32'h0,       32'h0,        ALU_ADD));

        // Power-on reset
        rst = 1'b1;
        drive(nop, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", bus.ex_valid, 0);
        chk("reset_bub", bus.bubble_count, 0);
        rst = 1'b0;
        #1;
        chk("reset_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vector table
        foreach (tab[k]) begin
            drive(tab[k].ins, tab[k].flush, tab[k].exr, tab[k].mem_rd, tab[k].mem_we, tab[k].mem_res,
                  tab[k].wb_rd, tab[k].wb_we, tab[k].wb_res);
            #3;
            chk($sformatf("v%0d_ready", k), bus.in_ready, tab[k].e_ready);
            chk($sformatf("v%0d_valid", k), bus.ex_valid, tab[k].e_valid);
            chk($sformatf("v%0d_rw", k), bus.ex_reg_write, tab[k].e_rw);
            chk($sformatf("v%0d_mr", k), bus.ex_mem_read, tab[k].e_mr);
            chk($sformatf("v%0d_bub", k), bus.bubble_count, tab[k].e_bub);
            if (tab[k].chk_ab) begin
                chk($sformatf("v%0d_a", k), bus.alu_a, tab[k].e_a);
                chk($sformatf("v%0d_b", k), bus.alu_b, tab[k].e_b);
                chk($sformatf("v%0d_ctrl", k), 32'(bus.alu_ctrl), 32'(tab[k].e_ctrl));
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while an instruction is held under a stall
        drive(mk_ins(1, 1, 32'hAA, 2, 32'hBB, 0, 0, 5, 1, 1, ALU_SLT), 0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_pre_valid", bus.ex_valid, 1);
        drive(nop, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", bus.ex_valid, 0);
        chk("rst_mid_a", bus.alu_a, 0);
        chk("rst_mid_b", bus.alu_b, 0);
        chk("rst_mid_ctrl", 32'(bus.alu_ctrl), 32'(ALU_ADD));
        chk("rst_mid_rd", 32'(bus.ex_rd), 0);
        chk("rst_mid_rw", bus.ex_reg_write, 0);
        chk("rst_mid_mr", bus.ex_mem_read, 0);
        chk("rst_mid_bub", bus.bubble_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_post_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        m_v   = 1'b0;
        m_h   = nop;
        m_bub = 0;
        cur   = nop;
        for (int c = 0; c < 2000; c++) begin
            logic        fl, exr, mwe, wwe, hold, lu, rdy, keep;
            logic [4:0]  mrd, wrd;
            logic [31:0] mres, wres, ea, eb;
            keep = (c > 0) && cur.v && !bus.in_ready && !bus.flush;
            if (!keep) begin
                cur = mk_ins($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                             5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             $urandom_range(0, 9) < 3, alu_ops_t'($urandom_range(0, 9)));
            end
            fl   = ($urandom_range(0, 15) == 0);
            exr  = ($urandom_range(0, 4) != 0);
            mrd  = 5'($urandom_range(0, 7));
            mwe  = 1'($urandom_range(0, 1));
            mres = $urandom;
            wrd  = 5'($urandom_range(0, 7));
            wwe  = 1'($urandom_range(0, 1));
            wres = $urandom;
            drive(cur, fl, exr, mrd, mwe, mres, wrd, wwe, wres);
            #3;
            hold = m_v && !exr;
            lu   = m_v && m_h.mr && (m_h.rd != 0) && cur.v &&
                   ((m_h.rd == cur.rs1) || (!cur.use_imm && m_h.rd == cur.rs2));
            rdy  = !hold && !lu && !fl;
            ea   = m_src(m_h.rs1, m_h.d1, mrd, mwe, mres, wrd, wwe, wres);
            eb   = m_h.use_imm ? m_h.imm : m_src(m_h.rs2, m_h.d2, mrd, mwe, mres, wrd, wwe, wres);
            chk("rnd_ready", bus.in_ready, rdy);
            chk("rnd_valid", bus.ex_valid, m_v);
            chk("rnd_a", bus.alu_a, ea);
            chk("rnd_b", bus.alu_b, eb);
            chk("rnd_ctrl", 32'(bus.alu_ctrl), 32'(m_h.op));
            chk("rnd_rd", 32'(bus.ex_rd), 32'(m_h.rd));
            chk("rnd_rw", bus.ex_reg_write, m_v && m_h.rw);
            chk("rnd_mr", bus.ex_mem_read, m_v && m_h.mr);
            chk("rnd_bub", bus.bubble_count, m_bub);
            if (fl) begin
                m_v = 1'b0;
            end else if (hold) begin
                m_v = m_v;
            end else if (lu) begin
                m_v   = 1'b0;
                m_bub = m_bub + 1;
            end else if (cur.v) begin
                m_h = cur;
                m_v = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
